// File: rtl/monitor_clock_gen_pkg.sv
// Shared constants for the monitor clock generator: register map, bit indices, FSM states.
package monitor_clock_gen_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DIV    = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int unsigned CTRL_LEVEL    = 0;
  localparam int unsigned CTRL_RUN      = 1;
  localparam int unsigned CTRL_STOP     = 2;
  localparam int unsigned CTRL_IRQ_MASK = 3;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_OUT  = 1;
  localparam int unsigned STAT_OVR  = 2;
  localparam int unsigned STAT_DONE = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/monitor_clock_gen_timer.sv
// Loadable down-counter timing one output phase; expires when the count reaches zero.
module monitor_clock_gen_timer #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic             expire_c
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_c = (cnt_q == '0);

endmodule

// File: rtl/monitor_clock_gen.sv
// Avalon-MM clock generator for the cdecv target: static level, N-pulse bursts, free run.
// Optional irq output enabled by defining MONITOR_CLOCK_GEN_IRQ_EN.
module monitor_clock_gen
  import monitor_clock_gen_pkg::*;
#(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port
`ifdef MONITOR_CLOCK_GEN_IRQ_EN
  ,
  output logic        irq
`endif
);

  state_e           state_q, state_d;
  logic             level_q, level_d;
  logic             run_q, run_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             ovr_q, ovr_d;
  logic             done_q, done_d;
  logic             out_q, out_d;
`ifdef MONITOR_CLOCK_GEN_IRQ_EN
  logic             mask_q, mask_d;
  logic             irq_q, irq_d;
`endif

  logic we, wr_ctrl, wr_div, wr_count, wr_status, stop;
  logic count_busy, timer_load, timer_expire;
  logic unused_wdata;

  assign unused_wdata = ^writedata;

  assign we        = chipselect && !write_n;
  assign wr_ctrl   = we && (address == ADDR_CTRL);
  assign wr_div    = we && (address == ADDR_DIV);
  assign wr_count  = we && (address == ADDR_COUNT);
  assign wr_status = we && (address == ADDR_STATUS);
  assign stop      = wr_ctrl && writedata[CTRL_STOP];

  // A pending burst counts as busy so a second COUNT write cannot overwrite it
  assign count_busy = (state_q != IDLE) || run_q || (rem_q != '0);

  monitor_clock_gen_timer #(.DIV_W(DIV_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (div_q),
    .expire_c (timer_expire)
  );

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    run_d      = run_q;
    div_d      = div_q;
    rem_d      = rem_q;
    ovr_d      = ovr_q;
    done_d     = done_q;
    out_d      = level_q;
    timer_load = 1'b0;
`ifdef MONITOR_CLOCK_GEN_IRQ_EN
    mask_d     = mask_q;
`endif

    if (wr_ctrl) begin
      level_d = writedata[CTRL_LEVEL];
      run_d   = writedata[CTRL_RUN] && !writedata[CTRL_STOP];
`ifdef MONITOR_CLOCK_GEN_IRQ_EN
      mask_d  = writedata[CTRL_IRQ_MASK];
`endif
    end
    if (wr_div) begin
      div_d = writedata[DIV_W-1:0];
    end
    // Clears first so a coincident set event below wins
    if (wr_status) begin
      if (writedata[STAT_OVR])  ovr_d  = 1'b0;
      if (writedata[STAT_DONE]) done_d = 1'b0;
    end
    if (wr_count) begin
      if (count_busy) begin
        ovr_d = 1'b1;
      end else if (writedata[CNT_W-1:0] != '0) begin
        rem_d = writedata[CNT_W-1:0];
      end
    end

    case (state_q)
      IDLE: begin
        if (run_q || (rem_q != '0)) state_d = HIGH;
      end
      HIGH: begin
        if (timer_expire) state_d = LOW;
      end
      LOW: begin
        if (timer_expire) begin
          if (rem_q != '0) rem_d = rem_q - CNT_W'(1);
          if (run_q || (rem_q > CNT_W'(1))) begin
            state_d = HIGH;
          end else begin
            state_d = IDLE;
            if (rem_q == CNT_W'(1)) done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (stop) begin
      state_d = IDLE;
      rem_d   = '0;
      run_d   = 1'b0;
    end

    timer_load = (state_d != state_q) && (state_d != IDLE);

    case (state_d)
      HIGH:    out_d = 1'b1;
      LOW:     out_d = 1'b0;
      default: out_d = level_q;
    endcase

`ifdef MONITOR_CLOCK_GEN_IRQ_EN
    irq_d = done_d && mask_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      level_q <= 1'b0;
      run_q   <= 1'b0;
      div_q   <= '0;
      rem_q   <= '0;
      ovr_q   <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= 1'b0;
`ifdef MONITOR_CLOCK_GEN_IRQ_EN
      mask_q  <= 1'b0;
      irq_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      run_q   <= run_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      ovr_q   <= ovr_d;
      done_q  <= done_d;
      out_q   <= out_d;
`ifdef MONITOR_CLOCK_GEN_IRQ_EN
      mask_q  <= mask_d;
      irq_q   <= irq_d;
`endif
    end
  end

  assign out_port = out_q;
`ifdef MONITOR_CLOCK_GEN_IRQ_EN
  assign irq = irq_q;
`endif

  // Zero-latency read mux
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_LEVEL] = level_q;
        readdata[CTRL_RUN]   = run_q;
`ifdef MONITOR_CLOCK_GEN_IRQ_EN
        readdata[CTRL_IRQ_MASK] = mask_q;
`endif
      end
      ADDR_DIV:   readdata = 32'(div_q);
      ADDR_COUNT: readdata = 32'(rem_q);
      default: begin
        readdata[STAT_BUSY] = (state_q != IDLE);
        readdata[STAT_OUT]  = out_q;
        readdata[STAT_OVR]  = ovr_q;
        readdata[STAT_DONE] = done_q;
      end
    endcase
  end

endmodule
